// File: rtl/pipeline_stall_controller.sv
// Prioritised stall/flush sequencer for the 5-stage core with a data-memory wait watchdog.
// Optional perf counters are enabled with `define PERF_COUNTERS_EN.
module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_EX_memRead,
  input  logic [4:0]       ID_EX_rt,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             IF_IDWrite,
  output logic             IF_IDFlush,
  output logic             ID_EXWrite,
  output logic             ID_EXBubble,
  output logic             EX_MEMWrite,
  output logic             MEM_WBBubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {INIT, RUN, MEM_WAIT, ERROR} state_t;

  typedef struct packed {
    logic pc_wr;
    logic ifid_wr;
    logic ifid_flush;
    logic idex_wr;
    logic idex_bubble;
    logic exmem_wr;
    logic memwb_bubble;
  } ctrl_t;

  localparam ctrl_t C_INIT     = 7'b0010101;
  localparam ctrl_t C_FREEZE   = 7'b0000001;
  localparam ctrl_t C_BRANCH   = 7'b1111110;
  localparam ctrl_t C_LOAD_USE = 7'b0001110;
  localparam ctrl_t C_NORMAL   = 7'b1101010;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  ctrl_t            ctrl;
  ctrl_t            run_ctrl;
  logic             load_use;
  logic             mem_stall;

  always_comb begin
    load_use  = ID_EX_memRead && (ID_EX_rt != 5'd0) &&
                ((ID_EX_rt == IF_ID_rs) || (ID_EX_rt == IF_ID_rt));
    mem_stall = dmem_req && !dmem_ready;
    // A taken branch flushes the younger instruction, so its load-use hazard is moot.
    run_ctrl  = branch_taken ? C_BRANCH : (load_use ? C_LOAD_USE : C_NORMAL);
    ctrl      = C_FREEZE;
    case (state)
      INIT:     ctrl = C_INIT;
      RUN:      ctrl = mem_stall ? C_FREEZE : run_ctrl;
      MEM_WAIT: ctrl = dmem_ready ? run_ctrl : C_FREEZE;
      default:  ctrl = C_FREEZE;
    endcase
  end

  assign PCWrite      = ctrl.pc_wr;
  assign IF_IDWrite   = ctrl.ifid_wr;
  assign IF_IDFlush   = ctrl.ifid_flush;
  assign ID_EXWrite   = ctrl.idex_wr;
  assign ID_EXBubble  = ctrl.idex_bubble;
  assign EX_MEMWrite  = ctrl.exmem_wr;
  assign MEM_WBBubble = ctrl.memwb_bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        INIT: state <= RUN;
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
            // Compare the pre-increment count: MEM_TIMEOUT full cycles spent in MEM_WAIT.
            if (MEM_TIMEOUT != 0 && wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
              state       <= ERROR;
              mem_timeout <= 1'b1;
            end
          end
        end
        default: begin
          state       <= ERROR;
          mem_timeout <= 1'b1;
        end
      endcase
    end
  end

`ifdef PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else if (state != INIT) begin
      if (!ctrl.pc_wr && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (ctrl.ifid_flush && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_stall_controller;

  localparam int CNT_W = 4;

  // {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXBubble, EX_MEMWrite, MEM_WBBubble, mem_timeout}
  localparam logic [7:0] E_INIT = 8'b00101010;
  localparam logic [7:0] E_FRZ  = 8'b00000010;
  localparam logic [7:0] E_ERR  = 8'b00000011;
  localparam logic [7:0] E_BR   = 8'b11111100;
  localparam logic [7:0] E_LU   = 8'b00011100;
  localparam logic [7:0] E_NORM = 8'b11010100;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  logic ID_EX_memRead, branch_taken, dmem_req, dmem_ready;
  logic [4:0] ID_EX_rt, IF_ID_rs, IF_ID_rt;
  logic PCWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXBubble, EX_MEMWrite, MEM_WBBubble;
  logic mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  sb_t sb_q[$];
  int  n_vec = 0;
  int  n_bad = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_EX_memRead(ID_EX_memRead), .ID_EX_rt(ID_EX_rt),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite), .IF_IDFlush(IF_IDFlush),
    .ID_EXWrite(ID_EXWrite), .ID_EXBubble(ID_EXBubble), .EX_MEMWrite(EX_MEMWrite),
    .MEM_WBBubble(MEM_WBBubble), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // Outputs are combinational, so each pushed expectation is checked mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      sb_t e;
      logic [7:0] got;
      e   = sb_q.pop_front();
      got = {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXBubble,
             EX_MEMWrite, MEM_WBBubble, mem_timeout};
      n_vec++;
      if (got !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %b expected %b", e.name, got, e.exp);
      end
    end
  end

  // Drive one cycle of inputs just after the posedge; optionally queue the expected outputs.
  task automatic apply(input logic mr, input logic [4:0] exrt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br, input logic req, input logic rdy,
                       input logic chk, input logic [7:0] exp, input string name);
    ID_EX_memRead = mr; ID_EX_rt = exrt; IF_ID_rs = rs; IF_ID_rt = rt;
    branch_taken = br; dmem_req = req; dmem_ready = rdy;
    if (chk) sb_q.push_back('{exp, name});
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic [7:0] exp, input string name);
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, exp, name);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_INIT, "");
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_INIT, "");
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (stall_cycles !== '0 || flush_count !== '0) begin
      n_bad++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles, flush_count);
    end
    idle(E_INIT, "init_cycle");
    idle(E_NORM, "run_after_init");
  endtask

  task automatic test_load_use();
    apply(1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, E_LU,   "lu_rs_match");
    apply(1'b0, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, E_NORM, "lu_resolved");
    apply(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, E_LU,   "lu_rt_match");
    apply(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_NORM, "lu_reg0");
    apply(1'b1, 5'd3, 5'd4, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, E_NORM, "lu_no_match");
    apply(1'b0, 5'd3, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, E_NORM, "lu_not_load");
  endtask

  task automatic test_branch();
    apply(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, E_BR,   "branch_over_lu");
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, E_BR,   "branch_plain");
    idle(E_NORM, "after_branch");
  endtask

  task automatic test_mem_wait();
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, E_FRZ,  "mw_entry_over_br");
    apply(1'b1, 5'd2, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, E_FRZ,  "mw_wait1");
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, E_FRZ,  "mw_wait2");
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, E_NORM, "mw_ready");
    idle(E_NORM, "mw_back_in_run");
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, E_NORM, "mw_ready_on_entry");
    idle(E_NORM, "mw_no_visit");
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, E_FRZ,  "mw2_entry");
    apply(1'b1, 5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b1, E_LU,   "mw2_ready_lu");
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, E_FRZ,  "mw3_entry");
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, E_BR,   "mw3_ready_br");
    idle(E_NORM, "mw3_run");
  endtask

  task automatic test_timeout();
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, E_FRZ, "to_entry");
    for (int i = 1; i <= 4; i++)
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, E_FRZ, $sformatf("to_wait%0d", i));
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, E_ERR, "to_error");
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, E_ERR, "to_sticky_ready");
    idle(E_ERR, "to_sticky_idle");
    do_reset();
    idle(E_INIT, "to_rst_init");
    idle(E_NORM, "to_rst_run");
  endtask

  task automatic test_perf_counters();
    logic [CNT_W-1:0] exp_stall, exp_flush;
`ifdef PERF_COUNTERS_EN
    exp_stall = '1;
    exp_flush = CNT_W'(3);
`else
    exp_stall = '0;
    exp_flush = '0;
`endif
    do_reset();
    idle(E_INIT, "pc_init");
    for (int i = 0; i < 20; i++)
      apply(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_LU, "pc_stall");
    for (int i = 0; i < 3; i++)
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, E_BR, "pc_flush");
    n_vec++;
    if (stall_cycles !== exp_stall) begin
      n_bad++;
      $display("FAIL perf_stall_cycles: got %0d expected %0d", stall_cycles, exp_stall);
    end
    n_vec++;
    if (flush_count !== exp_flush) begin
      n_bad++;
      $display("FAIL perf_flush_count: got %0d expected %0d", flush_count, exp_flush);
    end
  endtask

  initial begin
    rst = 1'b1;
    ID_EX_memRead = 1'b0; ID_EX_rt = '0; IF_ID_rs = '0; IF_ID_rt = '0;
    branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_perf_counters();
    @(negedge clk);
    @(posedge clk);
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
